// File: rtl/fdiv_pkg.sv
// Shared constants, helper function and per-channel state type for the
// multi-channel programmable frequency divider.
package fdiv_pkg;

    localparam int                    FDIV_WIDTH       = 32;
    localparam logic [FDIV_WIDTH-1:0] FDIV_DEFAULT_DIV = 32'd25000000;

    // State is held at the full package width; narrower WIDTH builds zero-extend into it.
    typedef struct packed {
        logic [FDIV_WIDTH-1:0] active;
        logic [FDIV_WIDTH-1:0] shadow;
        logic [FDIV_WIDTH-1:0] count;
        logic                  pending;
        logic                  out_clock;
        logic                  tick;
    } channel_state_t;

    function automatic int fdiv_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fdiv_chan.sv
// One divider channel: counts enabled cycles, pulses tick and toggles out_clock
// every D cycles, and swaps in a shadowed divisor only at a period boundary.
module fdiv_chan
    import fdiv_pkg::*;
#(
    parameter int               WIDTH       = FDIV_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(FDIV_DEFAULT_DIV)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic             load,
    input  logic [WIDTH-1:0] load_div,
    output logic             tick,
    output logic             out_clock,
    output logic             pending
);

    localparam logic [FDIV_WIDTH-1:0] ONE = FDIV_WIDTH'(1);
    localparam channel_state_t RESET_STATE = '{
        active:    FDIV_WIDTH'(DEFAULT_DIV),
        shadow:    FDIV_WIDTH'(DEFAULT_DIV),
        count:     '0,
        pending:   1'b0,
        out_clock: 1'b0,
        tick:      1'b0
    };

    channel_state_t        state;
    channel_state_t        state_next;
    logic [FDIV_WIDTH-1:0] load_val;
    logic                  running;
    logic                  boundary;

    // A running channel always has active >= 1, so active-1 cannot underflow.
    always_comb begin
        load_val = FDIV_WIDTH'(load_div);
        running  = enable && (state.active != '0);
        boundary = running && (state.count == state.active - ONE);
    end

    always_comb begin
        state_next      = state;
        state_next.tick = 1'b0;
        if (restart) begin
            state_next.count     = '0;
            state_next.out_clock = 1'b0;
            state_next.pending   = 1'b0;
            if (load) begin
                state_next.active = load_val;
                state_next.shadow = load_val;
            end else if (state.pending) begin
                state_next.active = state.shadow;
            end
        end else if (boundary) begin
            state_next.count     = '0;
            state_next.tick      = 1'b1;
            state_next.out_clock = ~state.out_clock;
            state_next.pending   = 1'b0;
            if (load) begin
                state_next.active = load_val;
                state_next.shadow = load_val;
            end else if (state.pending) begin
                state_next.active = state.shadow;
            end
        end else begin
            if (running) begin
                state_next.count = state.count + ONE;
            end
            if (load) begin
                state_next.shadow  = load_val;
                state_next.pending = 1'b1;
            end else if (!running && state.pending) begin
                // Restarting the phase keeps count in range of a smaller divisor.
                state_next.active  = state.shadow;
                state_next.pending = 1'b0;
                state_next.count   = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    assign tick      = state.tick;
    assign out_clock = state.out_clock;
    assign pending   = state.pending;

endmodule

// File: rtl/fdiv_multi.sv
// Multi-channel runtime-programmable frequency divider: write-port decode and
// acknowledge around CHANNELS independent fdiv_chan instances.
module fdiv_multi
    import fdiv_pkg::*;
#(
    parameter int               CHANNELS    = 4,
    parameter int               WIDTH       = FDIV_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(FDIV_DEFAULT_DIV),
    localparam int              CHAN_BITS   = fdiv_clog2(CHANNELS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  enable,
    input  logic                 restart,
    input  logic                 wr_en,
    input  logic [CHAN_BITS-1:0] wr_chan,
    input  logic [WIDTH-1:0]     wr_div,
    output logic                 wr_ack,
    output logic                 wr_err,
    output logic [CHANNELS-1:0]  pending,
    output logic [CHANNELS-1:0]  tick,
    output logic [CHANNELS-1:0]  out_clock
);

    logic                wr_valid;
    logic [CHANNELS-1:0] load;

    // Non-power-of-two channel counts leave select codes that must be rejected.
    always_comb begin
        wr_valid = wr_en && (int'(wr_chan) < CHANNELS);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign load[i] = wr_valid && (wr_chan == CHAN_BITS'(i));

        fdiv_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .enable    (enable[i]),
            .restart   (restart),
            .load      (load[i]),
            .load_div  (wr_div),
            .tick      (tick[i]),
            .out_clock (out_clock[i]),
            .pending   (pending[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_valid;
            wr_err <= wr_en && !wr_valid;
        end
    end

endmodule

// File: tb/tb_fdiv_multi.sv
// Self-checking bench for fdiv_multi: a cycle-level behavioural model checked every
// cycle, plus hand-computed literal expectations at key cycles.
module tb_fdiv_multi;

    localparam int              NCH = 3;
    localparam int              W   = 32;
    localparam logic [W-1:0]    DEF = 32'd3;

    logic           clock = 1'b0;
    logic           reset;
    logic [NCH-1:0] enable;
    logic           restart;
    logic           wr_en;
    logic [1:0]     wr_chan;
    logic [W-1:0]   wr_div;
    logic           wr_ack;
    logic           wr_err;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] out_clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    longint m_active [NCH];
    longint m_shadow [NCH];
    longint m_cnt    [NCH];
    bit     m_pend   [NCH];
    bit     m_oc     [NCH];
    bit     m_tick   [NCH];
    bit     m_ack;
    bit     m_err;

    fdiv_multi #(
        .CHANNELS    (NCH),
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .restart   (restart),
        .wr_en     (wr_en),
        .wr_chan   (wr_chan),
        .wr_div    (wr_div),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .pending   (pending),
        .tick      (tick),
        .out_clock (out_clock)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] vecOf(input int sel);
        logic [31:0] v = '0;
        for (int i = 0; i < NCH; i++) begin
            case (sel)
                0:       v[i] = m_tick[i];
                1:       v[i] = m_oc[i];
                default: v[i] = m_pend[i];
            endcase
        end
        return v;
    endfunction

    // Pin DUT and model together against a hand-computed value.
    task automatic checkLit(input string name, input logic [31:0] dut_val,
                            input logic [31:0] model_val, input logic [31:0] lit);
        checkOutput({name, "_dut"}, dut_val, lit);
        checkOutput({name, "_model"}, model_val, lit);
    endtask

    // Behavioural model: one step per rising edge, following the divider rules directly.
    task automatic modelStep();
        bit wr_ok;
        bit wr_here;
        if (reset) begin
            cyc   = 0;
            m_ack = 1'b0;
            m_err = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_active[i] = longint'(DEF);
                m_shadow[i] = longint'(DEF);
                m_cnt[i]    = 0;
                m_pend[i]   = 1'b0;
                m_oc[i]     = 1'b0;
                m_tick[i]   = 1'b0;
            end
            return;
        end
        cyc++;
        wr_ok = wr_en && (int'(wr_chan) < NCH);
        m_ack = wr_ok;
        m_err = wr_en && !wr_ok;
        for (int i = 0; i < NCH; i++) begin
            wr_here   = wr_ok && (int'(wr_chan) == i);
            m_tick[i] = 1'b0;
            if (restart) begin
                m_cnt[i] = 0;
                m_oc[i]  = 1'b0;
                if (wr_here) m_active[i] = longint'(wr_div);
                else if (m_pend[i]) m_active[i] = m_shadow[i];
                m_pend[i] = 1'b0;
            end else if (enable[i] && m_active[i] != 0) begin
                if (m_cnt[i] + 1 == m_active[i]) begin
                    m_tick[i] = 1'b1;
                    m_oc[i]   = !m_oc[i];
                    m_cnt[i]  = 0;
                    if (wr_here) m_active[i] = longint'(wr_div);
                    else if (m_pend[i]) m_active[i] = m_shadow[i];
                    m_pend[i] = 1'b0;
                end else begin
                    m_cnt[i]++;
                    if (wr_here) begin
                        m_shadow[i] = longint'(wr_div);
                        m_pend[i]   = 1'b1;
                    end
                end
            end else if (wr_here) begin
                m_shadow[i] = longint'(wr_div);
                m_pend[i]   = 1'b1;
            end else if (m_pend[i]) begin
                m_active[i] = m_shadow[i];
                m_pend[i]   = 1'b0;
                m_cnt[i]    = 0;
            end
        end
    endtask

    always @(posedge clock) begin
        modelStep();
        #1;
        checkOutput("tick", 32'(tick), vecOf(0));
        checkOutput("out_clock", 32'(out_clock), vecOf(1));
        checkOutput("pending", 32'(pending), vecOf(2));
        checkOutput("wr_ack", 32'(wr_ack), 32'(m_ack));
        checkOutput("wr_err", 32'(wr_err), 32'(m_err));
    end

    task automatic gotoCycle(input int n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge clock);
            guard++;
        end
        if (cyc < n) begin
            checks++;
            failures++;
            $display("[TB] FAIL goto_cycle actual=%0d expected=%0d", cyc, n);
        end
    endtask

    // Drive one cycle of write/restart during cycle n, then release.
    task automatic applyStimulus(input int n, input bit we, input logic [1:0] ch,
                                 input logic [W-1:0] div, input bit rs);
        gotoCycle(n);
        wr_en   = we;
        wr_chan = ch;
        wr_div  = div;
        restart = rs;
        gotoCycle(n + 1);
        wr_en   = 1'b0;
        restart = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset   = 1'b1;
        enable  = 3'b001;
        restart = 1'b0;
        wr_en   = 1'b0;
        wr_chan = '0;
        wr_div  = '0;
        repeat (3) @(negedge clock);
        checkLit("rst_tick", 32'(tick), vecOf(0), 32'h0);
        checkLit("rst_oc", 32'(out_clock), vecOf(1), 32'h0);
        checkLit("rst_pend", 32'(pending), vecOf(2), 32'h0);
        checkLit("rst_ack", 32'(wr_ack), 32'(m_ack), 32'h0);
        reset = 1'b0;

        gotoCycle(3);
        checkLit("c3_tick", 32'(tick), vecOf(0), 32'h1);
        checkLit("c3_oc", 32'(out_clock), vecOf(1), 32'h1);

        applyStimulus(4, 1'b1, 2'd0, 32'd5, 1'b0);
        checkLit("c5_pend", 32'(pending), vecOf(2), 32'h1);
        checkLit("c5_ack", 32'(wr_ack), 32'(m_ack), 32'h1);
        gotoCycle(6);
        checkLit("c6_tick", 32'(tick), vecOf(0), 32'h1);
        checkLit("c6_oc", 32'(out_clock), vecOf(1), 32'h0);
        checkLit("c6_pend", 32'(pending), vecOf(2), 32'h0);
        gotoCycle(11);
        checkLit("c11_tick", 32'(tick), vecOf(0), 32'h1);
        gotoCycle(16);
        checkLit("c16_tick", 32'(tick), vecOf(0), 32'h1);

        applyStimulus(17, 1'b1, 2'd1, 32'd2, 1'b0);
        checkLit("c18_pend", 32'(pending), vecOf(2), 32'h2);
        gotoCycle(19);
        checkLit("c19_pend", 32'(pending), vecOf(2), 32'h0);
        gotoCycle(20);
        enable = 3'b011;
        gotoCycle(22);
        checkLit("c22_tick", 32'(tick), vecOf(0), 32'h2);
        gotoCycle(23);
        checkLit("c23_tick", 32'(tick), vecOf(0), 32'h0);
        gotoCycle(24);
        checkLit("c24_tick", 32'(tick), vecOf(0), 32'h2);

        applyStimulus(25, 1'b1, 2'd0, 32'd7, 1'b0);
        checkLit("c26_pend", 32'(pending), vecOf(2), 32'h0);
        checkLit("c26_ack", 32'(wr_ack), 32'(m_ack), 32'h1);
        checkLit("c26_tick", 32'(tick), vecOf(0), 32'h3);
        gotoCycle(33);
        checkLit("c33_tick0", 32'(tick[0]), 32'(m_tick[0]), 32'h1);

        applyStimulus(35, 1'b1, 2'd3, 32'd9, 1'b0);
        checkLit("c36_err", 32'(wr_err), 32'(m_err), 32'h1);
        checkLit("c36_ack", 32'(wr_ack), 32'(m_ack), 32'h0);
        checkLit("c36_pend", 32'(pending), vecOf(2), 32'h0);

        applyStimulus(37, 1'b1, 2'd0, 32'd4, 1'b0);
        applyStimulus(38, 1'b1, 2'd1, 32'd4, 1'b0);
        applyStimulus(39, 1'b1, 2'd2, 32'd4, 1'b0);
        gotoCycle(40);
        enable = 3'b111;
        applyStimulus(42, 1'b0, 2'd0, 32'd0, 1'b1);
        checkLit("c43_oc", 32'(out_clock), vecOf(1), 32'h0);
        checkLit("c43_pend", 32'(pending), vecOf(2), 32'h0);
        gotoCycle(47);
        checkLit("c47_tick", 32'(tick), vecOf(0), 32'h7);
        checkLit("c47_oc", 32'(out_clock), vecOf(1), 32'h7);
        gotoCycle(51);
        checkLit("c51_tick", 32'(tick), vecOf(0), 32'h7);

        applyStimulus(52, 1'b1, 2'd0, 32'd6, 1'b0);
        applyStimulus(53, 1'b1, 2'd0, 32'd9, 1'b0);
        applyStimulus(54, 1'b1, 2'd2, 32'd1, 1'b0);
        gotoCycle(57);
        enable = 3'b101;
        gotoCycle(61);
        enable = 3'b111;
        applyStimulus(65, 1'b1, 2'd1, 32'd0, 1'b0);
        applyStimulus(70, 1'b1, 2'd0, 32'd2, 1'b1);
        checkLit("c71_ack", 32'(wr_ack), 32'(m_ack), 32'h1);
        checkLit("c71_oc", 32'(out_clock), vecOf(1), 32'h0);
        checkLit("c71_tick", 32'(tick), vecOf(0), 32'h0);

        gotoCycle(80);
        reset  = 1'b1;
        enable = 3'b001;
        @(negedge clock);
        checkLit("mid_rst_tick", 32'(tick), vecOf(0), 32'h0);
        checkLit("mid_rst_oc", 32'(out_clock), vecOf(1), 32'h0);
        reset = 1'b0;
        gotoCycle(3);
        checkLit("r3_tick", 32'(tick), vecOf(0), 32'h1);
        gotoCycle(4);
        checkLit("r4_tick", 32'(tick), vecOf(0), 32'h0);
        gotoCycle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fdiv_multi.md
Name: fdiv_multi

Overview:
- Multi-channel, runtime-programmable successor to the fixed single-output frequency divider.
- Each of CHANNELS independent channels produces two outputs from the system clock:
  - a one-cycle tick enable;
  - a 50% duty square out_clock.
- Divisors are written at run time through a simple write port. Each write lands in a shadow register and is applied glitch-free at the channel's next period boundary.
- Sits beside the DMX timing logic: drives break/MAB/slot bit-rate enables and status LED blink rates.

Parameters:
- CHANNELS, 4: number of independent divider channels (1..16).
- WIDTH, 32: counter and divisor width in bits.
- DEFAULT_DIV, 32'd25000000: divisor loaded into every channel at reset (1 Hz square at 50 MHz).
- CHAN_BITS, $clog2(CHANNELS) (min 1): width of the channel select; derived, not overridden.

Ports:
- clock, input, 1: system clock, all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, CHANNELS: per-channel run enable.
- restart, input, 1: single-cycle pulse that phase-aligns all channels.
- wr_en, input, 1: divisor write strobe.
- wr_chan, input, CHAN_BITS: target channel of the write.
- wr_div, input, WIDTH: new divisor D. D=0 halts the channel.
- wr_ack, output, 1: pulses one cycle after a write to a valid channel is accepted.
- wr_err, output, 1: pulses one cycle after a write with wr_chan >= CHANNELS.
- pending, output, CHANNELS: shadow divisor waiting to be applied.
- tick, output, CHANNELS: one-cycle pulse every D enabled cycles.
- out_clock, output, CHANNELS: toggles on every tick; period 2*D cycles.

Behaviour:
- Reset is synchronous on reset=1 and overrides everything.
  - Per channel: active=shadow=DEFAULT_DIV, count=0, pending=0, tick=0, out_clock=0.
  - wr_ack=0, wr_err=0.
- Priority per cycle: reset > restart > write/boundary > normal count.
- Running channel, defined as enable[i]=1 and active!=0:
  - If count==active-1: count<=0, tick<=1, out_clock toggles. If pending: active<=shadow, pending<=0.
  - Else: count<=count+1, tick<=0.
- Compare arithmetic: active-1 is computed in WIDTH bits. It never underflows because a running channel has active>=1. Maximum D is 2^WIDTH-1.
- Latency: tick is registered. With count=0 and enable high from cycle 0, tick is high in cycle D (the cycle after count reaches D-1). D=1 gives tick every cycle and out_clock toggling every cycle.
- Stopped channel, defined as enable[i]=0 or active==0:
  - count and out_clock hold; tick=0.
  - A pending shadow is applied on the next cycle with count<=0, so a shrinking divisor cannot leave count beyond range.
- Write accepted (wr_en=1, wr_chan<CHANNELS):
  - shadow[wr_chan]<=wr_div, pending<=1; wr_ack=1 next cycle.
  - Back-to-back writes to one channel before the boundary: the last write wins.
- Write coinciding with that channel's boundary: wr_div goes directly to active, pending<=0. Old shadow is discarded.
- Invalid channel (wr_chan>=CHANNELS): no state change; wr_err=1 next cycle; wr_ack=0.
- restart=1, all channels:
  - count<=0, tick<=0, out_clock<=0.
  - Any pending shadow is applied immediately.
  - A write in the same cycle goes directly to active; wr_ack still pulses.
- Enable deasserted mid-period: phase is frozen. Re-enable resumes from the held count; no extra tick.
- Writing D=0 halts the channel at its next boundary: out_clock holds its level, tick stays 0.

Decomposition:
- Package fdiv_pkg holds:
  - default WIDTH and DEFAULT_DIV constants;
  - a clog2-with-minimum-1 helper function for CHAN_BITS;
  - a channel_state_t struct {active, shadow, count, pending, out_clock, tick}.
- Sub-module fdiv_chan (one divider channel) covers the count/compare/shadow/restart logic, with inputs enable, restart, load, load_div.
- fdiv_multi generates CHANNELS instances of fdiv_chan and owns write-port decode, wr_ack and wr_err.

Test Plan:
- Reset with DEFAULT_DIV overridden to 3, enable=4'b0001 -> ch0 tick at cycles 3,6,9; out_clock 0→1 at cycle 3, 1→0 at 6; other channels tick=0 and out_clock=0.
- Write D=5 to ch0 at cycle 4, mid-period -> pending[0]=1 and wr_ack high at cycle 5; ticks at 6 (old D=3) then 11, 16; pending clears after the cycle-6 boundary.
- Write D=2 to ch1 while enable[1]=0 -> applied next cycle with count=0; on enable at cycle 20, ticks at 22, 24.
- Write to ch0 in the exact boundary cycle with D=7 -> pending never asserts; next tick 7 cycles later; wr_ack=1.
- wr_chan=5 with CHANNELS=4 (CHAN_BITS=3 via CHANNELS=5 build check, or CHANNELS=3 with wr_chan=3) -> wr_err=1 one cycle later; no pending change; wr_ack=0.
- restart pulse mid-period with all enabled at D=4 -> all out_clock=0 and count=0; every channel ticks together 4 cycles later. Reset asserted mid-run -> all outputs 0 next cycle; active returns to DEFAULT_DIV.
